// File: rtl/processor_unit_pipe.sv
// rtl/processor_unit_pipe.sv - pipelined LANES-wide fp32 dot-product accumulator tile; optional beat counter under PU_BEAT_COUNT_EN

// fp_mult: combinational fp32 multiply.
// Round to nearest even. Denormal inputs and underflowing results are flushed to signed zero.
// Every NaN result is the canonical quiet NaN 0x7FC00000.
module fp_mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic              sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, hi, guard, sticky;
   logic [47:0]       prod;
   logic [23:0]       norm;
   logic [24:0]       rnd;
   logic signed [9:0] exp;

   // Multiply significands, renormalise by at most one bit, round, then resolve special operands
   always_comb begin
      sign   = a[31] ^ b[31];
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      hi     = prod[47];
      norm   = hi ? prod[47:24] : prod[46:23];
      guard  = hi ? prod[23] : prod[22];
      sticky = hi ? (|prod[22:0]) : (|prod[21:0]);
      rnd    = {1'b0, norm} + {24'd0, guard & (sticky | norm[0])};
      exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
             + $signed({9'd0, hi}) + $signed({9'd0, rnd[24]});
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         y = 32'h7FC00000;
      else if (a_inf || b_inf)
         y = {sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         y = {sign, 31'd0};
      else if (exp >= 10'sd255)
         y = {sign, 8'hFF, 23'd0};
      else if (exp <= 10'sd0)
         y = {sign, 31'd0};
      else
         y = {sign, exp[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
   end
endmodule

// FloatingAddition: combinational fp32 add.
// Uses guard, round and sticky bits and rounds to nearest even.
// Denormals are flushed to zero, and an exact cancellation gives +0.
module FloatingAddition (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, sl, ss;
   logic [7:0]        el, es, d;
   logic [22:0]       fl, fs;
   logic [26:0]       ml, ms, mask, ms_al, n;
   logic [27:0]       raw;
   logic [4:0]        lz;
   logic [24:0]       rnd;
   logic signed [9:0] exp;

   // Align the smaller operand, add or subtract magnitudes, renormalise, round, then resolve specials
   always_comb begin
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      swap   = (b[30:0] > a[30:0]);
      {sl, el, fl} = swap ? b : a;
      {ss, es, fs} = swap ? a : b;
      ml     = {1'b1, fl, 3'b000};
      ms     = {1'b1, fs, 3'b000};
      d      = el - es;
      mask   = ~({27{1'b1}} << d);
      if (d > 8'd26)
         ms_al = 27'd1;
      else
         ms_al = (ms >> d) | {26'd0, |(ms & mask)};
      if (sl == ss)
         raw = {1'b0, ml} + {1'b0, ms_al};
      else
         raw = {1'b0, ml} - {1'b0, ms_al};
      exp = $signed({2'b00, el});
      lz  = 5'd0;
      if (raw[27]) begin
         n   = raw[27:1] | {26'd0, raw[0]};
         exp = exp + 10'sd1;
      end else begin
         for (int i = 0; i < 27; i++)
            if (raw[i]) lz = 5'(26 - i);
         n   = raw[26:0] << lz;
         exp = exp - $signed({5'd0, lz});
      end
      rnd = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
      exp = exp + $signed({9'd0, rnd[24]});
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
         y = 32'h7FC00000;
      else if (a_inf)
         y = a;
      else if (b_inf)
         y = b;
      else if (a_zero && b_zero)
         y = {a[31] & b[31], 31'd0};
      else if (a_zero)
         y = b;
      else if (b_zero)
         y = a;
      else if (raw == 28'd0)
         y = 32'd0;
      else if (exp >= 10'sd255)
         y = {sl, 8'hFF, 23'd0};
      else if (exp <= 10'sd0)
         y = {sl, 31'd0};
      else
         y = {sl, exp[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
   end
endmodule

// processor_unit_pipe: S1 registers the lane products. S2 chains the adds left to right into acc.
module processor_unit_pipe #(
   parameter int LANES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic [31:0]           in_previous,
   input  logic [LANES*32-1:0]   in_a,
   input  logic [LANES*32-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef PU_BEAT_COUNT_EN
   output logic [15:0]           out_beats,
`endif
   output logic [31:0]           out_data
);
   logic [LANES*32-1:0]     prod, s1_prod;
   logic [(LANES+1)*32-1:0] chain;
   logic                    s1_valid, s1_first, s1_last, s1_advance;
   logic [31:0]             s1_seed, acc, sum;

   genvar i;
   generate
      for (i = 0; i < LANES; i++) begin : g_lane
         fp_mult u_mult (
            .a (in_a[32*i +: 32]),
            .b (in_b[32*i +: 32]),
            .y (prod[32*i +: 32])
         );
         FloatingAddition u_add (
            .a (chain[32*i +: 32]),
            .b (s1_prod[32*i +: 32]),
            .y (chain[32*(i+1) +: 32])
         );
      end
   endgenerate

   // A last beat may only leave S1 when the output slot is free or being consumed this cycle
   assign chain[31:0] = s1_first ? s1_seed : acc;
   assign sum         = chain[32*LANES +: 32];
   assign s1_advance  = s1_valid && (!s1_last || !out_valid || out_ready);
   assign in_ready    = !s1_valid || s1_advance;

   // S1: capture products and packet flags on accept; the seed is only meaningful on a first beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_seed  <= 32'd0;
         s1_prod  <= '0;
      end else if (in_valid && in_ready) begin
         s1_valid <= 1'b1;
         s1_first <= in_first;
         s1_last  <= in_last;
         s1_prod  <= prod;
         if (in_first) s1_seed <= in_previous;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: fold the chained sum into acc, and publish it on a last beat
   // A simultaneous consume and new result keeps out_valid high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= 32'd0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
      end else begin
         if (s1_advance) acc <= sum;
         if (s1_advance && s1_last) begin
            out_valid <= 1'b1;
            out_data  <= sum;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef PU_BEAT_COUNT_EN
   logic [15:0] beat_cnt, beat_next;
   assign beat_next = s1_first ? 16'd1 : ((beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1);

   // Saturating per-packet beat count, latched alongside out_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt  <= 16'd0;
         out_beats <= 16'd0;
      end else if (s1_advance) begin
         beat_cnt <= beat_next;
         if (s1_last) out_beats <= beat_next;
      end
   end
`endif
endmodule

// File: tb/tb_processor_unit_pipe.sv
// tb/tb_processor_unit_pipe.sv - randomized and directed bench for processor_unit_pipe
module tb_processor_unit_pipe;
   logic        clk = 0;
   logic        rst = 1;
   logic        in_valid = 0, in_first = 0, in_last = 0, out_ready = 1;
   logic [31:0] in_previous = 0;
   logic [63:0] in_a = 0, in_b = 0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
`ifdef PU_BEAT_COUNT_EN
   logic [15:0] out_beats;
`endif
   logic         in_valid4 = 0, in_first4 = 0, in_last4 = 0, out_ready4 = 1;
   logic [31:0]  in_previous4 = 0;
   logic [127:0] in_a4 = 0, in_b4 = 0;
   logic         in_ready4, out_valid4;
   logic [31:0]  out_data4;
`ifdef PU_BEAT_COUNT_EN
   logic [15:0]  out_beats4;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   processor_unit_pipe #(.LANES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_first(in_first), .in_last(in_last), .in_previous(in_previous),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PU_BEAT_COUNT_EN
      .out_beats(out_beats),
`endif
      .out_data(out_data)
   );

   processor_unit_pipe #(.LANES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_first(in_first4), .in_last(in_last4), .in_previous(in_previous4),
      .in_a(in_a4), .in_b(in_b4), .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef PU_BEAT_COUNT_EN
      .out_beats(out_beats4),
`endif
      .out_data(out_data4)
   );

   typedef struct {
      logic        first;
      logic        last;
      logic [31:0] prev;
      logic [63:0] a;
      logic [63:0] b;
   } beat_t;

   // Exact fp32 encoding of n * 2^-sh for |n| < 2^24
   function automatic logic [31:0] to_f32(input int n, input int sh);
      int          m, p;
      logic [31:0] mm;
      if (n == 0) return 32'd0;
      m = (n < 0) ? -n : n;
      p = 0;
      for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
      mm = 32'(m) << (23 - p);
      return {(n < 0) ? 1'b1 : 1'b0, 8'(127 + p - sh), mm[22:0]};
   endfunction

   task automatic drive_beat(input logic first, input logic last, input logic [31:0] prev,
                             input logic [63:0] a, input logic [63:0] b);
      bit done = 0;
      @(negedge clk);
      in_valid = 1; in_first = first; in_last = last; in_previous = prev; in_a = a; in_b = b;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (in_ready === 1'b1) begin done = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
      end else begin
         @(posedge clk);
      end
      #1 in_valid = 0;
   endtask

   task automatic test_reset;
      rst = 1; out_ready = 1;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got=%h exp=00000000", out_data); end
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got=%b exp=0", out_valid4); end
`ifdef PU_BEAT_COUNT_EN
      checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL reset_out_beats: got=%h exp=0000", out_beats); end
`endif
      rst = 0;
   endtask

   task automatic test_single_beat;
      out_ready = 1;
      drive_beat(1, 1, 32'h3F800000, {32'h40400000, 32'h40000000}, {32'h3F800000, 32'h40000000});
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got=%b exp=1", out_valid); end
      checks++; if (out_data !== 32'h41000000) begin errors++; $display("FAIL single_data: got=%h exp=41000000", out_data); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got=%b exp=0", out_valid); end
   endtask

   task automatic test_two_beat;
      int          pulses = 0;
      logic [31:0] seen = 32'hDEADBEEF;
      out_ready = 1;
      drive_beat(1, 0, 32'd0, {32'h3F800000, 32'h3F800000}, {32'h3F800000, 32'h3F800000});
      drive_beat(0, 1, 32'd0, {32'h40000000, 32'h40000000}, {32'h3F800000, 32'h3F800000});
      repeat (5) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin pulses++; seen = out_data; end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL two_beat_pulses: got=%0d exp=1", pulses); end
      checks++; if (seen !== 32'h40C00000) begin errors++; $display("FAIL two_beat_data: got=%h exp=40C00000", seen); end
   endtask

   task automatic test_backpressure;
      out_ready = 0;
      drive_beat(1, 0, 32'd0, {32'h3F800000, 32'h3F800000}, {32'h3F800000, 32'h3F800000});
      drive_beat(0, 1, 32'd0, {32'h40000000, 32'h40000000}, {32'h3F800000, 32'h3F800000});
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h40C00000) begin
         errors++; $display("FAIL bp_first_result: valid=%b data=%h exp 1/40C00000", out_valid, out_data); end
      drive_beat(1, 1, 32'h3F800000, {32'h3F800000, 32'h00000000}, {32'h3F800000, 32'h00000000});
      repeat (3) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got=%b exp=0", in_ready); end
         checks++; if (out_valid !== 1'b1 || out_data !== 32'h40C00000) begin
            errors++; $display("FAIL bp_hold: valid=%b data=%h exp 1/40C00000", out_valid, out_data); end
      end
      out_ready = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got=%b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h40000000) begin
         errors++; $display("FAIL bp_next_result: valid=%b data=%h exp 1/40000000", out_valid, out_data); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_final_clear: got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_packet;
      out_ready = 1;
      drive_beat(1, 0, 32'd0, {32'h3F800000, 32'h3F800000}, {32'h3F800000, 32'h3F800000});
      rst = 1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rmid_out_data: got=%h exp=00000000", out_data); end
      checks++; if (dut.acc !== 32'd0) begin errors++; $display("FAIL rmid_acc: got=%h exp=00000000", dut.acc); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got=%b exp=1", in_ready); end
      rst = 0;
      drive_beat(1, 1, 32'h3F800000, 64'd0, 64'd0);
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h3F800000) begin
         errors++; $display("FAIL rmid_restart: valid=%b data=%h exp 1/3F800000", out_valid, out_data); end
   endtask

   task automatic test_lanes4;
      bit done = 0;
      out_ready4 = 1;
      @(negedge clk);
      in_valid4 = 1; in_first4 = 1; in_last4 = 1; in_previous4 = 32'h3F000000;
      in_a4 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
      in_b4 = {4{32'h3F800000}};
      #1 done = (in_ready4 === 1'b1);
      checks++; if (!done) begin errors++; $display("FAIL lanes4_ready: got=%b exp=1", in_ready4); end
      @(posedge clk);
      #1 in_valid4 = 0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid4 !== 1'b1 || out_data4 !== 32'h41280000) begin
         errors++; $display("FAIL lanes4_data: valid=%b data=%h exp 1/41280000", out_valid4, out_data4); end
   endtask

`ifdef PU_BEAT_COUNT_EN
   task automatic test_beat_count;
      out_ready = 1;
      drive_beat(1, 0, 32'd0, 64'd0, 64'd0);
      drive_beat(0, 0, 32'd0, 64'd0, 64'd0);
      drive_beat(0, 1, 32'd0, 64'd0, 64'd0);
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_beats !== 16'd3) begin
         errors++; $display("FAIL beats_three: valid=%b beats=%0d exp 1/3", out_valid, out_beats); end
      drive_beat(1, 1, 32'd0, 64'd0, 64'd0);
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_beats !== 16'd1) begin
         errors++; $display("FAIL beats_one: valid=%b beats=%0d exp 1/1", out_valid, out_beats); end
   endtask
`endif

   task automatic test_random;
      beat_t       beats[$];
      logic [31:0] exp_q[$];
      logic [31:0] held, e;
      beat_t       bt;
      int          q = 0, nb, x, y, s, idx = 0, cycles = 0;
      bit          hold = 0;
      for (int p = 0; p < 40; p++) begin
         nb = int'($urandom_range(1, 4));
         for (int j = 0; j < nb; j++) begin
            bt.first = (j == 0) && (p == 0 || $urandom_range(3) != 0);
            bt.last  = (j == nb - 1);
            s = int'($urandom_range(80)) - 40;
            bt.prev = to_f32(s, 2);
            if (bt.first) q = s;
            for (int l = 0; l < 2; l++) begin
               x = int'($urandom_range(12)) - 6;
               y = int'($urandom_range(12)) - 6;
               bt.a[32*l +: 32] = to_f32(x, 1);
               bt.b[32*l +: 32] = to_f32(y, 1);
               q += x * y;
            end
            beats.push_back(bt);
         end
         exp_q.push_back(to_f32(q, 2));
      end
      while ((idx < beats.size() || exp_q.size() > 0) && cycles < 4000) begin
         @(negedge clk);
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               errors++; $display("FAIL rand_stable: valid=%b data=%h exp 1/%h", out_valid, out_data, held); end
         end
         out_ready = ($urandom_range(3) != 0);
         if (idx < beats.size() && $urandom_range(4) != 0) begin
            in_valid = 1; in_first = beats[idx].first; in_last = beats[idx].last;
            in_previous = beats[idx].prev; in_a = beats[idx].a; in_b = beats[idx].b;
         end else begin
            in_valid = 0;
         end
         #1;
         hold = out_valid && !out_ready;
         held = out_data;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_extra: data=%h exp none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin errors++; $display("FAIL rand_data: got=%h exp=%h", out_data, e); end
            end
         end
         if (in_valid && in_ready) idx++;
         cycles++;
      end
      in_valid = 0; out_ready = 1;
      checks++;
      if (exp_q.size() != 0 || idx != beats.size()) begin
         errors++; $display("FAIL rand_complete: pending=%0d beats_sent=%0d exp 0/%0d", exp_q.size(), idx, beats.size()); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_two_beat();
      test_backpressure();
      test_reset_mid_packet();
      test_lanes4();
`ifdef PU_BEAT_COUNT_EN
      test_beat_count();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/processor_unit_pipe.md
# processor_unit_pipe

Parametrised, pipelined successor to the two-lane combinational processing unit. Computes an IEEE-754 single-precision dot product of LANES operand pairs per beat and accumulates it over a multi-beat packet, seeded from an upstream partial sum. It is a registered tile for the systolic/matrix datapath, built from the existing combinational `fp_mult` and `FloatingAddition` primitives. Valid/ready handshakes sit on both input and output.

## Interface
- LANES, 2 — product pairs per beat (≥1); instantiates LANES `fp_mult` and LANES `FloatingAddition`.
- clk  input  1  — sole clock, rising edge.
- rst  input  1  — asynchronous, active-high reset.
- in_valid  input  1  — beat present.
- in_ready  output  1  — beat accepted when in_valid && in_ready at a rising edge.
- in_first  input  1  — beat opens a packet; seed = in_previous.
- in_last  input  1  — beat closes a packet; result emitted.
- in_previous  input  32  — seed partial sum (sampled only when in_first).
- in_a  input  LANES*32  — operand A; lane i at [32i+31:32i].
- in_b  input  LANES*32  — operand B; same packing.
- out_valid  output  1  — result held.
- out_ready  input  1  — result consumed when out_valid && out_ready at a rising edge.
- out_data  output  32  — packet result.

## Operation
- Stage 1 (S1): on accept, register the LANES products a_i*b_i, plus first/last/seed, into S1; s1_valid ← 1.
- Stage 2 (S2): base = s1_first ? s1_seed : acc. sum = (((base + p0) + p1) + … + p_{LANES-1}), chained left to right in lane order. This order is mandatory for bit-exact results.
- S1 advances when s1_valid && (!s1_last || !out_valid || out_ready). On advance: acc ← sum. If s1_last, also out_data ← sum and out_valid ← 1.
- in_ready = !s1_valid || s1_advance. This is combinational; a full pipeline accepts a new beat in the same cycle S1 drains.
- out_valid clears on consume unless a new last beat advances in the same cycle, in which case it stays 1 with new data.
- in_first && in_last in one beat is a single-beat packet.
- A beat without in_first after a completed packet continues from acc (the last result). This is defined behaviour, not an error.
- Arithmetic, rounding, and special values are exactly those of `fp_mult`/`FloatingAddition`; no extra normalisation.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0x00000000, acc 0, s1_valid 0.
- Latency: a last beat accepted at edge N gives out_valid=1 with the result after edge N+1 (one cycle after acceptance), provided the output slot is free.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, a last beat stalls in S1 and in_ready=0. Non-last beats still drain into acc.
- out_data and out_valid are stable while out_valid && !out_ready.
- Reset mid-packet: the partial accumulation and S1 contents are discarded; the next packet must start with in_first.

## Configuration
- PU_BEAT_COUNT_EN defined: adds output `out_beats` [15:0].
  - It is a per-packet count of accepted beats, counted at S2 advance.
  - It resets to 1 on a first beat, increments otherwise, and saturates at 0xFFFF.
  - It is latched alongside out_data; reset value 0.
- PU_BEAT_COUNT_EN undefined: no port and no counter logic.

## Test plan
- Single beat, LANES=2: previous=0x3F800000 (1.0), a=(2.0,3.0), b=(2.0,1.0), first=last=1 → out_data=0x41000000 (8.0) one cycle after accept.
- Two-beat packet: previous=0; beat0 a=(1,1), b=(1,1); beat1 a=(2,2), b=(1,1), last → 0x40C00000 (6.0); exactly one out_valid pulse with out_ready=1.
- Backpressure: hold out_ready=0 after the 6.0 result and send a second single-beat packet → in_ready=0 while its last beat sits in S1; out_data stays 0x40C00000. Raise out_ready → next result appears the following cycle and no beat is lost.
- Reset mid-packet: assert rst after beat0 of a two-beat packet → out_valid=0, out_data=0, acc=0. A new single-beat packet seeded with 1.0 and a=b=(0,0) → 0x3F800000.
- LANES=4 regression: a=(1,2,3,4), b=(1,1,1,1), previous=0.5 → 0x41280000 (10.5).
- With PU_BEAT_COUNT_EN: 3-beat packet → out_beats=3; immediately following 1-beat packet → out_beats=1.
